// File: rtl/jtvigil_vtgen_pkg.sv
// Default Vigilante video timing constants and the counter fold helper shared by jtvigil_vtgen.
package jtvigil_vtgen_pkg;

   // Measured on the original PCB: 6.144 MHz pixel clock, 384x284 total, 16.00 kHz H, 56.34 Hz V.
   localparam int VIGIL_HCNT_START = 0;
   localparam int VIGIL_HCNT_END   = 383;
   localparam int VIGIL_HB_START   = 265;
   localparam int VIGIL_HB_END     = 9;
   localparam int VIGIL_HS_START   = 305;
   localparam int VIGIL_HS_END     = 337;
   localparam int VIGIL_V_START    = 0;
   localparam int VIGIL_VCNT_END   = 283;
   localparam int VIGIL_VB_START   = 256;
   localparam int VIGIL_VB_END     = 0;
   localparam int VIGIL_VS_START   = 260;
   localparam int VIGIL_VS_END     = 263;

   localparam int OFFW = 4;

   // Folds a value that overshoots the counter range by less than one span back into it.
   function automatic int wrap_cnt(input int val, input int first, input int last);
      int span;
      span = last - first + 1;
      if (val > last)  return val - span;
      if (val < first) return val + span;
      return val;
   endfunction

endpackage

// File: rtl/jtvigil_vtgen_win.sv
// Wrap-aware window comparator: active for win_start <= cnt < win_end, wrapping when start > end.
module jtvigil_vtgen_win #(
   parameter int W = 9
) (
   input  logic [W-1:0] cnt,
   input  logic [W-1:0] win_start,
   input  logic [W-1:0] win_end,
   output logic         inwin
);

   always_comb begin
      inwin = 1'b0;
      if (win_start < win_end) begin
         inwin = (cnt >= win_start) && (cnt < win_end);
      end else if (win_start > win_end) begin
         inwin = (cnt >= win_start) || (cnt < win_end);
      end
   end

endmodule

// File: rtl/jtvigil_vtgen.sv
// Parametrised video timing generator for the Vigilante video top.
// Define JTVIGIL_VTGEN_SYNC_ADJ_EN to enable the runtime hoffset/voffset sync centring.
module jtvigil_vtgen
   import jtvigil_vtgen_pkg::*;
#(
   parameter int HW           = 9,
   parameter int VW           = 9,
   parameter int HCNT_START   = VIGIL_HCNT_START,
   parameter int HCNT_END     = VIGIL_HCNT_END,
   parameter int HB_START     = VIGIL_HB_START,
   parameter int HB_END       = VIGIL_HB_END,
   parameter int HS_START     = VIGIL_HS_START,
   parameter int HS_END       = VIGIL_HS_END,
   parameter int V_START      = VIGIL_V_START,
   parameter int VCNT_END     = VIGIL_VCNT_END,
   parameter int VB_START     = VIGIL_VB_START,
   parameter int VB_END       = VIGIL_VB_END,
   parameter int VS_START     = VIGIL_VS_START,
   parameter int VS_END       = VIGIL_VS_END,
   parameter int RENDER_AHEAD = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pxl_cen,
   input  logic [OFFW-1:0] hoffset,
   input  logic [OFFW-1:0] voffset,
   output logic [HW-1:0]   H,
   output logic [VW-1:0]   vdump,
   output logic [VW-1:0]   vrender,
   output logic            Hinit,
   output logic            Vinit,
   output logic            LHBL,
   output logic            LVBL,
   output logic            HS,
   output logic            VS
);

   logic [HW-1:0] h_nx;
   logic [VW-1:0] v_nx;
   logic          h_wrap;
   logic          vinit_nx;
   logic [HW-1:0] hs_start;
   logic [HW-1:0] hs_end;
   logic [VW-1:0] vs_start;
   logic [VW-1:0] vs_end;
   logic          hb_win;
   logic          hs_win;
   logic          vb_win;
   logic          vs_win;

   always_comb begin
      h_wrap   = (H == HW'(HCNT_END));
      h_nx     = h_wrap ? HW'(HCNT_START) : H + HW'(1);
      v_nx     = vdump;
      if (h_wrap) begin
         v_nx = (vdump == VW'(VCNT_END)) ? VW'(V_START) : vdump + VW'(1);
      end
      vinit_nx = (h_nx == HW'(HCNT_START)) && (v_nx == VW'(V_START));
   end

`ifdef JTVIGIL_VTGEN_SYNC_ADJ_EN
   logic [OFFW-1:0] ho;
   logic [OFFW-1:0] vo;

   // Offsets only move on the frame's first pixel so a sync pulse is never torn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ho <= '0;
         vo <= '0;
      end else if (pxl_cen && vinit_nx && !Vinit) begin
         ho <= hoffset;
         vo <= voffset;
      end
   end

   assign hs_start = HW'(wrap_cnt(HS_START + int'($signed(ho)), HCNT_START, HCNT_END));
   assign hs_end   = HW'(wrap_cnt(HS_END   + int'($signed(ho)), HCNT_START, HCNT_END));
   assign vs_start = VW'(wrap_cnt(VS_START + int'($signed(vo)), V_START, VCNT_END));
   assign vs_end   = VW'(wrap_cnt(VS_END   + int'($signed(vo)), V_START, VCNT_END));
`else
   logic unused_offsets;

   assign unused_offsets = ^{hoffset, voffset};
   assign hs_start       = HW'(HS_START);
   assign hs_end         = HW'(HS_END);
   assign vs_start       = VW'(VS_START);
   assign vs_end         = VW'(VS_END);
`endif

   jtvigil_vtgen_win #(.W(HW)) u_hb (
      .cnt       (h_nx),
      .win_start (HW'(HB_START)),
      .win_end   (HW'(HB_END)),
      .inwin     (hb_win)
   );

   jtvigil_vtgen_win #(.W(HW)) u_hs (
      .cnt       (h_nx),
      .win_start (hs_start),
      .win_end   (hs_end),
      .inwin     (hs_win)
   );

   jtvigil_vtgen_win #(.W(VW)) u_vb (
      .cnt       (v_nx),
      .win_start (VW'(VB_START)),
      .win_end   (VW'(VB_END)),
      .inwin     (vb_win)
   );

   jtvigil_vtgen_win #(.W(VW)) u_vs (
      .cnt       (v_nx),
      .win_start (vs_start),
      .win_end   (vs_end),
      .inwin     (vs_win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         H       <= HW'(HCNT_START);
         vdump   <= VW'(V_START);
         vrender <= VW'(wrap_cnt(V_START + RENDER_AHEAD, V_START, VCNT_END));
         Hinit   <= 1'b0;
         Vinit   <= 1'b0;
         LHBL    <= 1'b0;
         LVBL    <= 1'b0;
         HS      <= 1'b0;
         VS      <= 1'b0;
      end else if (pxl_cen) begin
         H       <= h_nx;
         vdump   <= v_nx;
         vrender <= VW'(wrap_cnt(int'(v_nx) + RENDER_AHEAD, V_START, VCNT_END));
         Hinit   <= (h_nx == HW'(HCNT_START));
         Vinit   <= vinit_nx;
         LHBL    <= !hb_win;
         HS      <= hs_win;
         if (h_wrap) LVBL <= !vb_win;
         // VS edges line up with the HS leading edge.
         if (h_nx == hs_start) VS <= vs_win;
      end
   end

endmodule

// File: tb/tb_jtvigil_vtgen.sv
// Self-checking bench for jtvigil_vtgen: three instances (default timing, short lines, and short
// lines with RENDER_AHEAD=3) checked every clock against a behavioural model via a scoreboard.
module tb_jtvigil_vtgen;

   typedef struct packed {
      logic [8:0] h;
      logic [8:0] vd;
      logic [8:0] vr;
      logic       hinit;
      logic       vinit;
      logic       lhbl;
      logic       lvbl;
      logic       hs;
      logic       vs;
   } vt_t;

   typedef struct packed {
      vt_t a;
      vt_t b;
      vt_t c;
   } exp_t;

   typedef struct {
      int hend; int hbs; int hbe; int hss; int hse;
      int vbs;  int vbe; int vss; int vse; int ra;
   } cfg_t;

   typedef struct {
      vt_t o;
      int  ho;
      int  vo;
   } mst_t;

   localparam int VSPAN = 284;
   localparam int BFRAME = 48 * VSPAN;

`ifdef JTVIGIL_VTGEN_SYNC_ADJ_EN
   localparam int RISE_NEG8 = 34;
   localparam int RISE_POS7 = 1;
   localparam int VS_OFF2   = 262;
`else
   localparam int RISE_NEG8 = 42;
   localparam int RISE_POS7 = 42;
   localparam int VS_OFF2   = 260;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic [3:0] hoffset = 4'd0;
   logic [3:0] voffset = 4'd0;

   logic [8:0] h_o [3];
   logic [8:0] vd_o [3];
   logic [8:0] vr_o [3];
   logic       hinit_o [3];
   logic       vinit_o [3];
   logic       lhbl_o [3];
   logic       lvbl_o [3];
   logic       hs_o [3];
   logic       vs_o [3];

   jtvigil_vtgen u_a (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hoffset(hoffset), .voffset(voffset),
      .H(h_o[0]), .vdump(vd_o[0]), .vrender(vr_o[0]), .Hinit(hinit_o[0]), .Vinit(vinit_o[0]),
      .LHBL(lhbl_o[0]), .LVBL(lvbl_o[0]), .HS(hs_o[0]), .VS(vs_o[0])
   );

   jtvigil_vtgen #(
      .HCNT_END(47), .HB_START(40), .HB_END(2), .HS_START(42), .HS_END(46)
   ) u_b (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hoffset(hoffset), .voffset(voffset),
      .H(h_o[1]), .vdump(vd_o[1]), .vrender(vr_o[1]), .Hinit(hinit_o[1]), .Vinit(vinit_o[1]),
      .LHBL(lhbl_o[1]), .LVBL(lvbl_o[1]), .HS(hs_o[1]), .VS(vs_o[1])
   );

   jtvigil_vtgen #(
      .HCNT_END(47), .HB_START(40), .HB_END(2), .HS_START(42), .HS_END(46), .RENDER_AHEAD(3)
   ) u_c (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hoffset(hoffset), .voffset(voffset),
      .H(h_o[2]), .vdump(vd_o[2]), .vrender(vr_o[2]), .Hinit(hinit_o[2]), .Vinit(vinit_o[2]),
      .LHBL(lhbl_o[2]), .LVBL(lvbl_o[2]), .HS(hs_o[2]), .VS(vs_o[2])
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   cfg_t cfg_a, cfg_b, cfg_c;
   mst_t ma, mb, mc;
   exp_t sb_q[$];

   int a_lhbl, a_lhbl_rise, a_hs, a_hs_rise, a_hinit;
   int b_lines, b_vinit, b_lvbl_lo, b_vs_cnt, b_vs_first, b_vs_last, b_hs_rise;
   logic prev_a_hs = 1'b0, prev_a_lhbl = 1'b0, prev_b_hs = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int md(input int x, input int n);
      return ((x % n) + n) % n;
   endfunction

   // Window membership as a modular distance test.
   function automatic logic win(input int c, input int s, input int e, input int n);
      return (s != e) && (md(c - s, n) < md(e - s, n));
   endfunction

   function automatic vt_t rst_state(input cfg_t c);
      vt_t r;
      r = '0;
      r.vr = 9'(md(c.ra, VSPAN));
      return r;
   endfunction

   function automatic vt_t step(input cfg_t c, input vt_t s, input int ho, input int vo);
      vt_t n;
      int hspan, h, v, hss, hse, vss, vse;
      logic hw;
      hspan = c.hend + 1;
      hw = (int'(s.h) == c.hend);
      h = hw ? 0 : int'(s.h) + 1;
      v = hw ? md(int'(s.vd) + 1, VSPAN) : int'(s.vd);
      hss = md(c.hss + ho, hspan);
      hse = md(c.hse + ho, hspan);
      vss = md(c.vss + vo, VSPAN);
      vse = md(c.vse + vo, VSPAN);
      n.h = 9'(h);
      n.vd = 9'(v);
      n.vr = 9'(md(v + c.ra, VSPAN));
      n.hinit = (h == 0);
      n.vinit = (h == 0) && (v == 0);
      n.lhbl = !win(h, c.hbs, c.hbe, hspan);
      n.hs = win(h, hss, hse, hspan);
      n.lvbl = hw ? !win(v, c.vbs, c.vbe, VSPAN) : s.lvbl;
      n.vs = (h == hss) ? win(v, vss, vse, VSPAN) : s.vs;
      return n;
   endfunction

   function automatic mst_t adv(input cfg_t c, input mst_t m, input logic cen, input logic r,
                                input int hin, input int vin);
      mst_t n;
      n = m;
      if (r) begin
         n.o = rst_state(c);
         n.ho = 0;
         n.vo = 0;
      end else if (cen) begin
         n.o = step(c, m.o, m.ho, m.vo);
`ifdef JTVIGIL_VTGEN_SYNC_ADJ_EN
         if (n.o.vinit && !m.o.vinit) begin
            n.ho = hin;
            n.vo = vin;
         end
`endif
      end
      return n;
   endfunction

   function automatic vt_t obs(input int i);
      return {h_o[i], vd_o[i], vr_o[i], hinit_o[i], vinit_o[i], lhbl_o[i], lvbl_o[i], hs_o[i],
              vs_o[i]};
   endfunction

   task automatic clear_stats();
      a_lhbl = 0; a_lhbl_rise = -1; a_hs = 0; a_hs_rise = -1; a_hinit = 0;
      b_lines = 0; b_vinit = 0; b_lvbl_lo = 0; b_vs_cnt = 0; b_vs_first = -1; b_vs_last = -1;
      b_hs_rise = -1;
   endtask

   task automatic tick(input logic cen, input logic r);
      exp_t e;
      int hin, vin;
      @(negedge clk);
      rst = r;
      pxl_cen = cen;
      hin = int'($signed(hoffset));
      vin = int'($signed(voffset));
      ma = adv(cfg_a, ma, cen, r, hin, vin);
      mb = adv(cfg_b, mb, cen, r, hin, vin);
      mc = adv(cfg_c, mc, cen, r, hin, vin);
      sb_q.push_back('{a: ma.o, b: mb.o, c: mc.o});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("state_a", obs(0), e.a);
      chk("state_b", obs(1), e.b);
      chk("state_c", obs(2), e.c);
      if (cen && !r) begin
         if (lhbl_o[0]) a_lhbl++;
         if (lhbl_o[0] && !prev_a_lhbl && a_lhbl_rise < 0) a_lhbl_rise = int'(h_o[0]);
         if (hs_o[0]) a_hs++;
         if (hs_o[0] && !prev_a_hs && a_hs_rise < 0) a_hs_rise = int'(h_o[0]);
         if (hinit_o[0]) a_hinit++;
         if (h_o[1] == 9'd0) b_lines++;
         if (vinit_o[1]) b_vinit++;
         if (h_o[1] == 9'd0 && !lvbl_o[1]) b_lvbl_lo++;
         if (h_o[1] == 9'd47 && vs_o[1]) begin
            b_vs_cnt++;
            if (b_vs_first < 0) b_vs_first = int'(vd_o[1]);
            b_vs_last = int'(vd_o[1]);
         end
         if (hs_o[1] && !prev_b_hs && b_hs_rise < 0) b_hs_rise = int'(h_o[1]);
         if (vd_o[1] == 9'd283 && h_o[1] == 9'd0) chk("vr_wrap_ra1", vr_o[1], 0);
         if (vd_o[2] == 9'd282 && h_o[2] == 9'd0) chk("vr_wrap_ra3", vr_o[2], 1);
         prev_a_hs = hs_o[0];
         prev_a_lhbl = lhbl_o[0];
         prev_b_hs = hs_o[1];
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
   endtask

   task automatic run8(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (7) tick(1'b0, 1'b0);
         tick(1'b1, 1'b0);
      end
   endtask

   task automatic chk_frame(input string tag, input int rise, input int vs_first);
      chk({tag, "_lines"}, b_lines, VSPAN);
      chk({tag, "_vinit"}, b_vinit, 1);
      chk({tag, "_lvbl_lo"}, b_lvbl_lo, 28);
      chk({tag, "_vs_cnt"}, b_vs_cnt, 3);
      chk({tag, "_vs_first"}, b_vs_first, vs_first);
      chk({tag, "_vs_last"}, b_vs_last, vs_first + 2);
      chk({tag, "_hs_rise"}, b_hs_rise, rise);
   endtask

   initial begin
      int found;
      cfg_a = '{383, 265, 9, 305, 337, 256, 0, 260, 263, 1};
      cfg_b = '{47, 40, 2, 42, 46, 256, 0, 260, 263, 1};
      cfg_c = cfg_b;
      cfg_c.ra = 3;
      ma = '{o: rst_state(cfg_a), ho: 0, vo: 0};
      mb = '{o: rst_state(cfg_b), ho: 0, vo: 0};
      mc = '{o: rst_state(cfg_c), ho: 0, vo: 0};
      clear_stats();

      repeat (3) tick(1'b1, 1'b1);
      chk("rst_a", obs(0), rst_state(cfg_a));
      chk("rst_c_vr", vr_o[2], 3);

      // Reset again in the middle of a line.
      run(100);
      repeat (2) tick(1'b1, 1'b1);
      chk("midrst_a", obs(0), rst_state(cfg_a));

      clear_stats();
      run8(1);
      chk("first_h", h_o[0], 1);
      chk("first_vd", vd_o[0], 0);
      run8(383);
      chk("a_lhbl_cnt", a_lhbl, 256);
      chk("a_lhbl_rise", a_lhbl_rise, 9);
      chk("a_hs_cnt", a_hs, 32);
      chk("a_hs_rise", a_hs_rise, 305);
      chk("a_hinit_cnt", a_hinit, 1);

      found = 0;
      for (int i = 0; i < BFRAME + 100 && found == 0; i++) begin
         tick(1'b1, 1'b0);
         if (vinit_o[1]) found = 1;
      end
      chk("b_align", found, 1);

      clear_stats();
      run(BFRAME);
      chk_frame("frame1", 42, 260);

      clear_stats();
      run(100 * 48);
      hoffset = 4'b1000;
      voffset = 4'd2;
      run(BFRAME - 100 * 48);
      chk_frame("frame2", 42, 260);

      clear_stats();
      run(100 * 48);
      hoffset = 4'd7;
      voffset = 4'd0;
      run(BFRAME - 100 * 48);
      chk_frame("frame3", RISE_NEG8, VS_OFF2);

      repeat (1000) tick(1'b0, 1'b0);
      chk("frozen_a", obs(0), ma.o);
      chk("frozen_b", obs(1), mb.o);

      clear_stats();
      run(BFRAME);
      chk_frame("frame4", RISE_POS7, 260);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
